// File: rtl/hamming_pcm_serializer.sv
// Hamming(7,4) encoder and serializer for 8-bit PCM samples: one holding register feeds a
// 14-bit frame shifter that emits one code bit per strobe of the divided bit-rate clock.
module hamming_pcm_serializer #(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic       clkIn,
  input  logic       reset,
  input  logic       clk_bitTransferRate,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       serial_out,
  output logic       bit_valid,
  output logic       frame_start,
  output logic       busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]  state;
  logic [3:0]  bit_cnt;
  logic [12:0] shift_reg;
  logic [13:0] hold_reg;
  logic        hold_valid;
  logic        rate_d;

  logic        bit_strobe;
  logic        accept;
  logic        last_bit;
  logic        load_frame;
  logic        advance;
  logic        finish;
  logic [13:0] enc_frame;

  // Bit 0 of the returned codeword is transmitted first: p1 p2 d1 p3 d2 d3 d4.
  function automatic logic [6:0] encode_nibble(input logic [3:0] n);
    logic d1, d2, d3, d4, p1, p2, p3;
    d1 = n[3];
    d2 = n[2];
    d3 = n[1];
    d4 = n[0];
    p1 = d1 ^ d2 ^ d4;
    p2 = d1 ^ d3 ^ d4;
    p3 = d2 ^ d3 ^ d4;
    return {d4, d3, d2, p3, d1, p2, p1};
  endfunction

  always_comb begin
    bit_strobe = clk_bitTransferRate & ~rate_d;
    accept     = data_valid & ~hold_valid;
    enc_frame  = {encode_nibble(data_in[3:0]), encode_nibble(data_in[7:4])};
    last_bit   = (state == ST_SHIFT) && (bit_cnt == 4'd13);
    load_frame = bit_strobe & hold_valid & ((state == ST_IDLE) | last_bit);
    advance    = bit_strobe & (state == ST_SHIFT) & ~last_bit;
    finish     = bit_strobe & last_bit & ~hold_valid;
  end

  // The shifter keeps only the bits not yet on the line; the bit being driven lives in serial_out.
  always_ff @(posedge clkIn) begin
    if (reset) begin
      rate_d      <= 1'b1;
      state       <= ST_IDLE;
      bit_cnt     <= 4'd0;
      shift_reg   <= 13'd0;
      hold_reg    <= 14'd0;
      hold_valid  <= 1'b0;
      serial_out  <= IDLE_LEVEL;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      rate_d      <= clk_bitTransferRate;
      frame_start <= 1'b0;
      if (accept) begin
        hold_reg   <= enc_frame;
        hold_valid <= 1'b1;
      end
      if (load_frame) begin
        shift_reg   <= hold_reg[13:1];
        serial_out  <= hold_reg[0];
        bit_valid   <= 1'b1;
        frame_start <= 1'b1;
        bit_cnt     <= 4'd0;
        state       <= ST_SHIFT;
        hold_valid  <= 1'b0;
      end else if (advance) begin
        shift_reg  <= {1'b0, shift_reg[12:1]};
        serial_out <= shift_reg[0];
        bit_cnt    <= bit_cnt + 4'd1;
      end else if (finish) begin
        serial_out <= IDLE_LEVEL;
        bit_valid  <= 1'b0;
        bit_cnt    <= 4'd0;
        state      <= ST_IDLE;
      end
    end
  end

  assign data_ready = ~hold_valid;
  assign busy       = (state == ST_SHIFT) | hold_valid;

endmodule

// File: tb/tb_hamming_pcm_serializer.sv
// Self-checking bench for hamming_pcm_serializer: directed vectors, multi-cycle corner cases and
// randomized traffic checked against a queue-based model of the transmitted bit stream.
module tb_hamming_pcm_serializer;

  logic       clkIn = 1'b0;
  logic       reset;
  logic       clk_bitTransferRate;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       serial_out;
  logic       bit_valid;
  logic       frame_start;
  logic       busy;

  always #5 clkIn = ~clkIn;

  hamming_pcm_serializer #(.IDLE_LEVEL(1'b0)) dut (
    .clkIn(clkIn),
    .reset(reset),
    .clk_bitTransferRate(clk_bitTransferRate),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .serial_out(serial_out),
    .bit_valid(bit_valid),
    .frame_start(frame_start),
    .busy(busy)
  );

  typedef struct {
    logic [7:0]  data;
    logic [13:0] exp_bits;
  } vec_t;

  vec_t       vecs[5];
  int         pass_count = 0;
  int         check_count = 0;
  int         cyc = 0;
  bit         rate_run = 0;
  int         rate_cnt = 0;
  logic       model_rate_d = 1'b1;
  bit         cap_q[$];
  logic [7:0] accepted_q[$];
  int         frame_start_cyc[$];
  logic       cur_bit = 1'b0;
  logic       cur_valid = 1'b0;
  bit         held_ok = 1;
  int         hold_cnt = 0;
  int         idle_err = 0;
  bit         last_accept = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // One clock: record handshake and strobe seen at the edge, monitor outputs #1 later, then drive the divider.
  task automatic tick();
    bit         acc;
    bit         strobe;
    logic [7:0] d;
    acc    = (data_valid === 1'b1) && (data_ready === 1'b1);
    d      = data_in;
    strobe = (clk_bitTransferRate === 1'b1) && (model_rate_d === 1'b0);
    @(posedge clkIn);
    #1;
    cyc++;
    last_accept = 0;
    if (reset) begin
      model_rate_d = 1'b1;
      accepted_q.delete();
      cap_q.delete();
      frame_start_cyc.delete();
      cur_valid = 1'b0;
      held_ok   = 1;
      hold_cnt  = 0;
    end else begin
      model_rate_d = clk_bitTransferRate;
      if (acc) begin
        accepted_q.push_back(d);
        last_accept = 1;
      end
      if (strobe) begin
        if (cur_valid) begin
          checkOutput("bit_hold_cycles", hold_cnt, 32);
          checkOutput("bit_hold_stable", int'(held_ok), 1);
        end
        if (bit_valid === 1'b1) begin
          checkOutput("frame_start_align", int'(frame_start), int'(cap_q.size() % 14 == 0));
          if (frame_start === 1'b1) frame_start_cyc.push_back(cyc);
          cap_q.push_back(serial_out);
        end else if (frame_start !== 1'b0) begin
          checkOutput("frame_start_idle", int'(frame_start), 0);
        end
        cur_bit   = serial_out;
        cur_valid = bit_valid;
        held_ok   = 1;
        hold_cnt  = 1;
      end else begin
        hold_cnt++;
        if (serial_out !== cur_bit || bit_valid !== cur_valid) held_ok = 0;
        if (frame_start !== 1'b0) checkOutput("frame_start_spurious", int'(frame_start), 0);
      end
      if (bit_valid !== 1'b1 && serial_out !== 1'b0) idle_err++;
    end
    if (rate_run) begin
      rate_cnt = (rate_cnt + 1) % 32;
      clk_bitTransferRate = (rate_cnt >= 16);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input string name);
    int n = 0;
    data_valid = 1'b1;
    data_in    = d;
    do begin
      tick();
      n++;
    end while (!last_accept && n < 1000);
    data_valid = 1'b0;
    checkOutput({name, "_accept"}, int'(last_accept), 1);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((busy !== 1'b0 || bit_valid !== 1'b0) && n < 3000) begin
      tick();
      n++;
    end
    checkOutput({name, "_idle_reached"}, int'(n < 3000), 1);
  endtask

  // Expected stream: each accepted byte, high nibble then low, as p1 p2 d1 p3 d2 d3 d4 with even parity.
  task automatic checkStream(input string name);
    bit exp_q[$];
    int nib, d1, d2, d3, d4, p1, p2, p3;
    foreach (accepted_q[k]) begin
      for (int h = 1; h >= 0; h--) begin
        nib = (int'(accepted_q[k]) >> (4 * h)) & 15;
        d1 = (nib >> 3) & 1;
        d2 = (nib >> 2) & 1;
        d3 = (nib >> 1) & 1;
        d4 = nib & 1;
        p1 = (d1 + d2 + d4) % 2;
        p2 = (d1 + d3 + d4) % 2;
        p3 = (d2 + d3 + d4) % 2;
        exp_q.push_back(bit'(p1));
        exp_q.push_back(bit'(p2));
        exp_q.push_back(bit'(d1));
        exp_q.push_back(bit'(p3));
        exp_q.push_back(bit'(d2));
        exp_q.push_back(bit'(d3));
        exp_q.push_back(bit'(d4));
      end
    end
    checkOutput({name, "_stream_len"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      checkOutput($sformatf("%s_bit%0d", name, i), int'(cap_q[i]), int'(exp_q[i]));
    checkOutput({name, "_idle_level"}, idle_err, 0);
    idle_err = 0;
    cap_q.delete();
    accepted_q.delete();
    frame_start_cyc.delete();
  endtask

  task automatic checkVector(input int k);
    for (int i = 0; i < 14; i++)
      checkOutput($sformatf("vec_%02h_bit%0d", vecs[k].data, i),
                  (i < cap_q.size()) ? int'(cap_q[i]) : 2, int'(vecs[k].exp_bits[i]));
  endtask

  initial begin
    int n;
    int prev_ready;
    int cyc_a;

    vecs[0] = '{8'hA5, 14'b10100100101101};
    vecs[1] = '{8'h3C, 14'b00111101100001};
    vecs[2] = '{8'h0F, 14'b11111110000000};
    vecs[3] = '{8'h12, 14'b01010101001011};
    vecs[4] = '{8'hFF, 14'h3FFF};

    reset = 1'b1;
    clk_bitTransferRate = 1'b1;
    data_valid = 1'b0;
    data_in = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checkOutput("rst_data_ready", int'(data_ready), 1);
    checkOutput("rst_serial_out", int'(serial_out), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_bit_valid", int'(bit_valid), 0);
    checkOutput("rst_frame_start", int'(frame_start), 0);

    // Rate held high through reset release: nothing may go out until a fresh rising edge.
    applyStimulus(8'hA5, "a5");
    repeat (40) tick();
    checkOutput("no_strobe_bit_valid", int'(bit_valid), 0);
    checkOutput("no_strobe_busy", int'(busy), 1);
    checkOutput("no_strobe_ready", int'(data_ready), 0);
    rate_cnt = 16;
    rate_run = 1;
    waitIdle("a5");
    checkOutput("a5_frame_starts", frame_start_cyc.size(), 1);
    checkVector(0);
    checkStream("a5");
    tick();
    checkOutput("a5_after_bit_valid", int'(bit_valid), 0);
    checkOutput("a5_after_serial", int'(serial_out), 0);

    for (int k = 0; k < 5; k++) begin
      applyStimulus(vecs[k].data, "vec");
      waitIdle("vec");
      checkVector(k);
      checkStream($sformatf("vec_%02h", vecs[k].data));
    end

    // Back-to-back 0x00 then 0xFF: second frame must follow with no idle bit.
    applyStimulus(8'h00, "b2b_00");
    applyStimulus(8'hFF, "b2b_ff");
    tick();
    checkOutput("b2b_ready_low", int'(data_ready), 0);
    checkOutput("b2b_busy", int'(busy), 1);
    n = 0;
    prev_ready = 0;
    while (frame_start_cyc.size() < 2 && n < 1000) begin
      prev_ready = int'(data_ready);
      tick();
      n++;
    end
    checkOutput("b2b_ready_before_xfer", prev_ready, 0);
    checkOutput("b2b_ready_after_xfer", int'(data_ready), 1);
    waitIdle("b2b");
    checkOutput("b2b_frame_starts", frame_start_cyc.size(), 2);
    checkOutput("b2b_frame_gap",
                (frame_start_cyc.size() == 2) ? frame_start_cyc[1] - frame_start_cyc[0] : -1, 448);
    checkStream("b2b");

    // Sample accepted on the strobe edge itself must wait one full bit period.
    n = 0;
    while (!(clk_bitTransferRate === 1'b1 && model_rate_d === 1'b0) && n < 100) begin
      tick();
      n++;
    end
    data_valid = 1'b1;
    data_in = 8'h5A;
    tick();
    data_valid = 1'b0;
    cyc_a = cyc;
    checkOutput("same_strobe_accept", int'(last_accept), 1);
    checkOutput("same_strobe_bit_valid", int'(bit_valid), 0);
    checkOutput("same_strobe_frame_start", int'(frame_start), 0);
    waitIdle("same_strobe");
    checkOutput("same_strobe_delay", (frame_start_cyc.size() == 1) ? frame_start_cyc[0] - cyc_a : -1, 32);
    checkStream("same_strobe");

    // Reset in the middle of 0x3C with 0x99 buffered.
    applyStimulus(8'h3C, "mid_3c");
    n = 0;
    while (cap_q.size() < 7 && n < 1000) begin
      tick();
      n++;
    end
    checkOutput("mid_reached_bit6", cap_q.size(), 7);
    applyStimulus(8'h99, "mid_99");
    checkOutput("mid_ready_full", int'(data_ready), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid_rst_serial", int'(serial_out), 0);
    checkOutput("mid_rst_bit_valid", int'(bit_valid), 0);
    checkOutput("mid_rst_frame_start", int'(frame_start), 0);
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_ready", int'(data_ready), 1);
    repeat (100) tick();
    checkOutput("mid_buffer_discarded", int'(busy), 0);
    checkOutput("mid_no_frames", frame_start_cyc.size(), 0);
    applyStimulus(8'h0F, "post_0f");
    waitIdle("post_0f");
    checkVector(2);
    checkStream("post_0f");

    // Continuous valid with changing data, then sporadic valid.
    data_valid = 1'b1;
    n = 0;
    while (accepted_q.size() < 6 && n < 6000) begin
      data_in = 8'($urandom);
      tick();
      n++;
    end
    data_valid = 1'b0;
    waitIdle("rand_cont");
    checkStream("rand_cont");
    for (int i = 0; i < 3000; i++) begin
      data_valid = ($urandom % 4 == 0);
      data_in = 8'($urandom);
      tick();
    end
    data_valid = 1'b0;
    waitIdle("rand_sparse");
    checkStream("rand_sparse");

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
